qam_symbol_scheduler: RTL and testbench

QAM_SYMBOL_SCHEDULER -- requirements
Module: qam_symbol_scheduler

---
 rtl/qam_pkg.sv | 12 +
 rtl/qam_bit_collector.sv | 47 ++++
 rtl/qam_symbol_scheduler.sv | 121 ++++++++++++
 tb/tb_qam_symbol_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared types and defaults for the QAM symbol scheduler slice.
package qam_pkg;

   localparam int unsigned PERIODS_PER_SYMBOL_DEFAULT = 4;
   localparam int unsigned PERIOD_CNT_W               = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } sched_state_e;

endpackage

// File: rtl/qam_bit_collector.sv
// Two-bit staging register for the serial payload: first bit is the sine sign,
// second bit is the cosine sign. A clear empties the stage when a symbol is loaded.
module qam_bit_collector (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_data_i,
   input  logic       bit_valid_i,
   input  logic       clear_i,
   output logic       bit_ready_o,
   output logic       stage_sin_o,
   output logic       stage_cos_o,
   output logic [1:0] stage_count_o
);

   logic [1:0] stage_q, stage_d;
   logic [1:0] count_q, count_d;
   logic       accept;

   assign bit_ready_o   = (count_q < 2'd2);
   assign accept        = bit_valid_i && bit_ready_o;
   assign stage_sin_o   = stage_q[0];
   assign stage_cos_o   = stage_q[1];
   assign stage_count_o = count_q;

   // A clear only happens with a full stage, when ready is low, so it never collides with an accept.
   always_comb begin
      stage_d = stage_q;
      count_d = count_q;
      if (clear_i) begin
         count_d = 2'd0;
      end else if (accept) begin
         stage_d[count_q[0]] = bit_data_i;
         count_d             = count_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= 2'b00;
         count_q <= 2'd0;
      end else begin
         stage_q <= stage_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Holds each staged (sin, cos) sign pair for PERIODS_PER_SYMBOL carrier periods,
// aligning symbol changes to carrier phase 0 and flagging underruns.
module qam_symbol_scheduler
   import qam_pkg::*;
#(
   parameter int unsigned PERIODS_PER_SYMBOL = PERIODS_PER_SYMBOL_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic carrier_start,
   input  logic bit_data,
   input  logic bit_valid,
   output logic bit_ready,
   output logic elojel_sin,
   output logic elojel_cos,
   output logic symbol_strobe,
   output logic busy,
   output logic underrun
);

   localparam logic [PERIOD_CNT_W-1:0] LAST_PERIOD = PERIOD_CNT_W'(PERIODS_PER_SYMBOL - 1);

   sched_state_e            state_q, state_d;
   logic [PERIOD_CNT_W-1:0] period_q, period_d;
   logic                    sin_q, sin_d;
   logic                    cos_q, cos_d;
   logic                    strobe_q, strobe_d;
   logic                    underrun_q, underrun_d;
   logic                    load;
   logic                    stage_sin;
   logic                    stage_cos;
   logic [1:0]              stage_count;
   logic                    stage_full;

   qam_bit_collector u_collector (
      .clk           (clk),
      .rst           (rst),
      .bit_data_i    (bit_data),
      .bit_valid_i   (bit_valid),
      .clear_i       (load),
      .bit_ready_o   (bit_ready),
      .stage_sin_o   (stage_sin),
      .stage_cos_o   (stage_cos),
      .stage_count_o (stage_count)
   );

   assign stage_full = (stage_count == 2'd2);

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      sin_d      = sin_q;
      cos_d      = cos_q;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      load       = 1'b0;

      case (state_q)
         IDLE: begin
            if (carrier_start && enable && stage_full) begin
               load = 1'b1;
            end
         end
         ACTIVE: begin
            // Enable is only consulted at a boundary so a running symbol is never cut short.
            if (carrier_start) begin
               if (period_q == LAST_PERIOD) begin
                  if (enable && stage_full) begin
                     load = 1'b1;
                  end else begin
                     state_d    = IDLE;
                     period_d   = '0;
                     sin_d      = 1'b0;
                     cos_d      = 1'b0;
                     underrun_d = enable;
                  end
               end else begin
                  period_d = period_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         state_d  = ACTIVE;
         period_d = '0;
         sin_d    = stage_sin;
         cos_d    = stage_cos;
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         period_q   <= '0;
         sin_q      <= 1'b0;
         cos_q      <= 1'b0;
         strobe_q   <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         sin_q      <= sin_d;
         cos_q      <= cos_d;
         strobe_q   <= strobe_d;
         underrun_q <= underrun_d;
      end
   end

   assign elojel_sin    = sin_q;
   assign elojel_cos    = cos_q;
   assign symbol_strobe = strobe_q;
   assign underrun      = underrun_q;
   assign busy          = (state_q == ACTIVE);

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Self-checking bench: a queue-based reference model of the scheduler is compared
// against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_qam_symbol_scheduler;

   localparam int P = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic carrier_start = 1'b0;
   logic bit_data = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_ready;
   logic elojel_sin;
   logic elojel_cos;
   logic symbol_strobe;
   logic busy;
   logic underrun;

   qam_symbol_scheduler #(.PERIODS_PER_SYMBOL(P)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .carrier_start (carrier_start),
      .bit_data      (bit_data),
      .bit_valid     (bit_valid),
      .bit_ready     (bit_ready),
      .elojel_sin    (elojel_sin),
      .elojel_cos    (elojel_cos),
      .symbol_strobe (symbol_strobe),
      .busy          (busy),
      .underrun      (underrun)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit chkEn = 1'b0;

   // reference model state
   bit mStaged[$];
   bit acceptedBits[$];
   bit mActive = 1'b0;
   int mPeriods = 0;
   bit mSin = 1'b0;
   bit mCos = 1'b0;
   bit mStrobe = 1'b0;
   bit mUnder = 1'b0;
   bit lastAccepted = 1'b0;

   // directed stimulus bookkeeping
   bit txBits[$];
   int tbPhase = 0;
   int strobeCount = 0;
   int underrunCount = 0;
   int strobeCycles[$];

   task automatic checkOutput(string name, logic actual, logic expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic checkCount(string name, int actual, int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Model: a symbol occupies P carrier periods; at its end the next staged pair is
   // shown if available and enabled, otherwise the outputs go quiet.
   always @(posedge clk) begin
      bit acc;
      bit doLoad;
      cyc++;
      acc = bit_valid && (mStaged.size() < 2);
      doLoad = 1'b0;
      lastAccepted = 1'b0;
      mStrobe = 1'b0;
      mUnder = 1'b0;
      if (rst) begin
         mStaged.delete();
         acceptedBits.delete();
         mActive = 1'b0;
         mPeriods = 0;
         mSin = 1'b0;
         mCos = 1'b0;
      end else begin
         if (carrier_start) begin
            if (!mActive) begin
               doLoad = enable && (mStaged.size() == 2);
            end else begin
               mPeriods++;
               if (mPeriods == P) begin
                  if (enable && mStaged.size() == 2) begin
                     doLoad = 1'b1;
                  end else begin
                     mUnder = enable;
                     mActive = 1'b0;
                     mSin = 1'b0;
                     mCos = 1'b0;
                  end
               end
            end
         end
         if (doLoad) begin
            mSin = mStaged[0];
            mCos = mStaged[1];
            mStaged.delete();
            mActive = 1'b1;
            mPeriods = 0;
            mStrobe = 1'b1;
         end
         if (acc) begin
            mStaged.push_back(bit_data);
            acceptedBits.push_back(bit_data);
            lastAccepted = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("elojel_sin", elojel_sin, mSin);
         checkOutput("elojel_cos", elojel_cos, mCos);
         checkOutput("symbol_strobe", symbol_strobe, mStrobe);
         checkOutput("busy", busy, mActive);
         checkOutput("underrun", underrun, mUnder);
         checkOutput("bit_ready", bit_ready, mStaged.size() < 2);
         if (symbol_strobe === 1'b1) begin
            strobeCount++;
            strobeCycles.push_back(cyc);
            if (acceptedBits.size() >= 2) begin
               bit sbSin;
               bit sbCos;
               sbSin = acceptedBits.pop_front();
               sbCos = acceptedBits.pop_front();
               checkOutput("scoreboard_sin", elojel_sin, sbSin);
               checkOutput("scoreboard_cos", elojel_cos, sbCos);
            end else begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL scoreboard: strobe with %0d sent bits pending, required 2", acceptedBits.size());
            end
         end
         if (underrun === 1'b1) underrunCount++;
      end
   end

   task automatic applyStimulus(int n, int csPer);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (lastAccepted && txBits.size() > 0) void'(txBits.pop_front());
         bit_valid = (txBits.size() > 0);
         bit_data = (txBits.size() > 0) ? txBits[0] : 1'b0;
         carrier_start = (csPer > 0) ? ((tbPhase % csPer) == (csPer - 1)) : 1'b0;
         tbPhase++;
      end
   endtask

   task automatic doReset();
      txBits.delete();
      rst = 1'b1;
      applyStimulus(2, 0);
      rst = 1'b0;
      tbPhase = 0;
   endtask

   initial begin
      int sBase;
      int uBase;
      doReset();
      chkEn = 1'b1;
      @(negedge clk);
      checkOutput("reset_bit_ready", bit_ready, 1'b1);
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_sin", elojel_sin, 1'b0);

      // bits 1,0 then one carrier_start
      enable = 1'b1;
      txBits = '{1'b1, 1'b0};
      applyStimulus(3, 0);
      applyStimulus(1, 1);
      applyStimulus(1, 0);
      @(negedge clk);
      checkOutput("first_sin", elojel_sin, 1'b1);
      checkOutput("first_cos", elojel_cos, 1'b0);
      checkOutput("first_strobe", symbol_strobe, 1'b1);
      checkOutput("first_busy", busy, 1'b1);

      // gapless stream of three symbols, carrier every 16 clocks
      doReset();
      enable = 1'b1;
      sBase = strobeCycles.size();
      uBase = underrunCount;
      txBits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      applyStimulus(150, 16);
      enable = 1'b0;
      applyStimulus(80, 16);
      checkCount("stream_strobes", strobeCycles.size() - sBase, 3);
      if (strobeCycles.size() - sBase >= 3) begin
         checkCount("stream_gap1", strobeCycles[sBase+1] - strobeCycles[sBase], 64);
         checkCount("stream_gap2", strobeCycles[sBase+2] - strobeCycles[sBase+1], 64);
      end
      checkCount("stream_underruns", underrunCount - uBase, 0);
      checkOutput("stream_end_busy", busy, 1'b0);

      // single symbol with enable high ends in an underrun
      doReset();
      enable = 1'b1;
      uBase = underrunCount;
      txBits = '{1'b1, 1'b1};
      applyStimulus(100, 16);
      checkCount("underrun_count", underrunCount - uBase, 1);
      checkOutput("underrun_busy", busy, 1'b0);
      checkOutput("underrun_sin", elojel_sin, 1'b0);

      // enable dropped mid-symbol: symbol still completes, no underrun
      doReset();
      enable = 1'b1;
      uBase = underrunCount;
      txBits = '{1'b0, 1'b1};
      applyStimulus(35, 16);
      enable = 1'b0;
      applyStimulus(30, 16);
      checkOutput("hold_busy", busy, 1'b1);
      checkOutput("hold_cos", elojel_cos, 1'b1);
      applyStimulus(30, 16);
      checkOutput("stop_busy", busy, 1'b0);
      checkCount("stop_underruns", underrunCount - uBase, 0);

      // reset mid-symbol with a full stage
      doReset();
      enable = 1'b1;
      txBits = '{1'b1, 1'b0, 1'b1, 1'b1};
      applyStimulus(40, 16);
      rst = 1'b1;
      applyStimulus(1, 16);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midreset_busy", busy, 1'b0);
      checkOutput("midreset_sin", elojel_sin, 1'b0);
      checkOutput("midreset_ready", bit_ready, 1'b1);
      sBase = strobeCount;
      applyStimulus(40, 16);
      checkCount("midreset_strobes", strobeCount - sBase, 0);

      // bit_valid held with a full stage: nothing lost or duplicated
      doReset();
      enable = 1'b1;
      sBase = strobeCount;
      uBase = underrunCount;
      for (int i = 0; i < 6; i++) txBits.push_back(1'($urandom_range(0, 1)));
      applyStimulus(20, 0);
      checkOutput("backpressure_ready", bit_ready, 1'b0);
      applyStimulus(200, 16);
      enable = 1'b0;
      applyStimulus(80, 16);
      checkCount("backpressure_strobes", strobeCount - sBase, 3);
      checkCount("backpressure_left", txBits.size(), 0);
      checkCount("backpressure_underruns", underrunCount - uBase, 0);

      // randomized traffic, dense then sparse payload
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 299) == 0);
         enable = ($urandom_range(0, 15) != 0);
         carrier_start = ($urandom_range(0, 4) == 0);
         bit_valid = (i < 1500) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 11) == 0);
         bit_data = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bit_valid = 1'b0;
      carrier_start = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
